// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART with TX/RX FIFOs, programmable divisor, sticky errors and a registered irq.
// Optional parity (CTRL bit4 par_odd, STATUS bit7 par_err) is enabled by defining UART_PARITY_EN.
module uart_mmio_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 434
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic                  re,
    input  logic [3:0]            addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  irq,
    output logic                  tx,
    input  logic                  rx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_t;

    logic [DIV_WIDTH-1:0] div_reg, div_eff, div_reload, half_reload;
    logic tx_en, rx_en, rx_irq_en, txe_irq_en;
    logic overrun, frame_err, par_err, par_odd;
    logic wr, sel_data, sel_status, sel_div, sel_ctrl;
    logic unused_bits;

    assign wr         = en & we;
    assign sel_data   = (addr[3:2] == 2'd0);
    assign sel_status = (addr[3:2] == 2'd1);
    assign sel_div    = (addr[3:2] == 2'd2);
    assign sel_ctrl   = (addr[3:2] == 2'd3);
    assign unused_bits = ^{wdata, addr[1:0]};

    // Every bit period reloads from div_eff, so a DIV write lands on the next bit boundary.
    assign div_eff     = (div_reg < DIV_MIN) ? DIV_MIN : div_reg;
    assign div_reload  = div_eff - DIV_ONE;
    assign half_reload = (div_eff >> 1) - DIV_ONE;

    // TX FIFO
    logic [7:0] tx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wptr, tx_rptr;
    logic tx_empty, tx_full, tx_push, tx_load;
    logic [7:0] tx_head;

    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_full  = (tx_wptr[AW] != tx_rptr[AW]) && (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
    assign tx_head  = tx_mem[tx_rptr[AW-1:0]];
    assign tx_push  = wr & sel_data & (~tx_full | tx_load);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_load) tx_rptr <= tx_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= wdata[7:0];
    end

    // TX FSM
    uart_state_t tx_state;
    logic [DIV_WIDTH-1:0] tx_cnt;
    logic [2:0] tx_idx;
    logic [7:0] tx_byte;
    logic tx_busy;

    assign tx_busy = (tx_state != S_IDLE);
    assign tx_load = tx_en & ~tx_empty &
                     ((tx_state == S_IDLE) | ((tx_state == S_STOP) & (tx_cnt == '0)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_byte  <= '0;
            tx       <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (tx_load) begin
                        tx_byte  <= tx_head;
                        tx       <= 1'b0;
                        tx_cnt   <= div_reload;
                        tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt != '0) tx_cnt <= tx_cnt - DIV_ONE;
                    else begin
                        tx_idx   <= '0;
                        tx       <= tx_byte[0];
                        tx_cnt   <= div_reload;
                        tx_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tx_cnt != '0) tx_cnt <= tx_cnt - DIV_ONE;
                    else begin
                        tx_cnt <= div_reload;
                        if (tx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            tx       <= (^tx_byte) ^ par_odd;
                            tx_state <= S_PARITY;
`else
                            tx       <= 1'b1;
                            tx_state <= S_STOP;
`endif
                        end else begin
                            tx_idx <= tx_idx + 3'd1;
                            tx     <= tx_byte[tx_idx + 3'd1];
                        end
                    end
                end
                S_PARITY: begin
                    if (tx_cnt != '0) tx_cnt <= tx_cnt - DIV_ONE;
                    else begin
                        tx       <= 1'b1;
                        tx_cnt   <= div_reload;
                        tx_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tx_cnt != '0) tx_cnt <= tx_cnt - DIV_ONE;
                    else if (tx_load) begin
                        tx_byte  <= tx_head;
                        tx       <= 1'b0;
                        tx_cnt   <= div_reload;
                        tx_state <= S_START;
                    end else begin
                        tx_state <= S_IDLE;
                    end
                end
                default: begin
                    tx_state <= S_IDLE;
                    tx       <= 1'b1;
                end
            endcase
        end
    end

    // RX synchroniser, FIFO and FSM
    logic rx_s1, rx_s2, rx_prev;
    logic [7:0] rx_mem [FIFO_DEPTH];
    logic [AW:0] rx_wptr, rx_rptr;
    logic rx_empty, rx_full, rx_push, rx_pop;
    logic [7:0] rx_head;
    uart_state_t rx_state;
    logic [DIV_WIDTH-1:0] rx_cnt;
    logic [2:0] rx_idx;
    logic [7:0] rx_shift;
    logic rx_par_ok, rx_stop_done, rx_frame_ok;

    assign rx_empty = (rx_wptr == rx_rptr);
    assign rx_full  = (rx_wptr[AW] != rx_rptr[AW]) && (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);
    assign rx_head  = rx_mem[rx_rptr[AW-1:0]];
    assign rx_pop   = en & re & sel_data & ~rx_empty;

    assign rx_stop_done = (rx_state == S_STOP) & (rx_cnt == '0);
    assign rx_frame_ok  = rx_stop_done & rx_s2 & rx_par_ok;
    assign rx_push      = rx_frame_ok & (~rx_full | rx_pop);

`ifdef UART_PARITY_EN
    logic rx_par_bad;
    assign rx_par_ok = ~rx_par_bad;
`else
    assign rx_par_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= rx_shift;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
`ifdef UART_PARITY_EN
            rx_par_bad <= 1'b0;
`endif
        end else begin
            case (rx_state)
                S_IDLE: begin
                    if (rx_en & rx_prev & ~rx_s2) begin
                        rx_cnt   <= half_reload;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt != '0) rx_cnt <= rx_cnt - DIV_ONE;
                    else if (!rx_s2) begin
                        rx_idx   <= '0;
                        rx_cnt   <= div_reload;
                        rx_state <= S_DATA;
                    end else begin
                        rx_state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (rx_cnt != '0) rx_cnt <= rx_cnt - DIV_ONE;
                    else begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_cnt   <= div_reload;
                        if (rx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            rx_state <= S_PARITY;
`else
                            rx_state <= S_STOP;
`endif
                        end else begin
                            rx_idx <= rx_idx + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (rx_cnt != '0) rx_cnt <= rx_cnt - DIV_ONE;
                    else begin
`ifdef UART_PARITY_EN
                        rx_par_bad <= ((^rx_shift) ^ par_odd) != rx_s2;
`endif
                        rx_cnt   <= div_reload;
                        rx_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (rx_cnt != '0) rx_cnt <= rx_cnt - DIV_ONE;
                    else rx_state <= S_IDLE;
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // Control/status registers; a new error event wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_reg    <= DIV_WIDTH'(DEFAULT_DIV);
            tx_en      <= 1'b1;
            rx_en      <= 1'b1;
            rx_irq_en  <= 1'b0;
            txe_irq_en <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            par_err    <= 1'b0;
            par_odd    <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (wr & sel_div) div_reg <= wdata[DIV_WIDTH-1:0];
            if (wr & sel_ctrl) begin
                tx_en      <= wdata[0];
                rx_en      <= wdata[1];
                rx_irq_en  <= wdata[2];
                txe_irq_en <= wdata[3];
`ifdef UART_PARITY_EN
                par_odd    <= wdata[4];
`endif
            end
            overrun   <= (overrun & ~(wr & sel_status & wdata[4])) |
                         (rx_frame_ok & rx_full & ~rx_pop);
            frame_err <= (frame_err & ~(wr & sel_status & wdata[5])) |
                         (rx_stop_done & ~rx_s2);
`ifdef UART_PARITY_EN
            par_err   <= (par_err & ~(wr & sel_status & wdata[7])) |
                         (rx_stop_done & rx_s2 & ~rx_par_ok);
`endif
            irq <= (rx_irq_en & ~rx_empty) | (txe_irq_en & tx_empty & ~tx_busy) |
                   overrun | frame_err | par_err;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr[3:2])
            2'd0: if (!rx_empty) rdata[7:0] = rx_head;
            2'd1: rdata[7:0] = {par_err, tx_busy, frame_err, overrun,
                                rx_empty, rx_full, tx_empty, tx_full};
            2'd2: rdata[DIV_WIDTH-1:0] = div_reg;
            default: rdata[4:0] = {par_odd, txe_irq_en, rx_irq_en, rx_en, tx_en};
        endcase
    end
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Randomised bench for uart_mmio_fifo: serial monitor/driver plus queue-based FIFO and status model.
module tb_uart_mmio_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0, we = 1'b0, re = 1'b0, rx = 1'b1;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq, tx;

    uart_mmio_fifo #(
        .DATA_WIDTH(32), .FIFO_DEPTH(16), .DIV_WIDTH(16), .DEFAULT_DIV(434)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .we(we), .re(re), .addr(addr),
        .wdata(wdata), .rdata(rdata), .irq(irq), .tx(tx), .rx(rx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_div  = 434;
    int cyc      = 0;
    int tx_stop_bad = 0;
    logic [7:0] tx_got[$];
    int         tx_start[$];
    logic [7:0] txm[$];
    logic [7:0] rxm[$];
    logic       m_ovr = 1'b0, m_ferr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        en = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        en = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        en = 1'b1; re = 1'b1; addr = a;
        #1 d = rdata;
        @(negedge clk);
        en = 1'b0; re = 1'b0;
    endtask

    // Status as software should see it with the transmitter idle.
    function automatic logic [31:0] exp_status();
        logic [7:0] s;
        s = 8'h02;
        s[2] = (rxm.size() == 16);
        s[3] = (rxm.size() == 0);
        s[4] = m_ovr;
        s[5] = m_ferr;
        return {24'h0, s};
    endfunction

    task automatic model_rx(input logic [7:0] b);
        if (rxm.size() < 16) rxm.push_back(b);
        else m_ovr = 1'b1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx = f[i];
            repeat (cur_div - 1) @(negedge clk);
        end
        @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k;
        k = 0;
        while (tx_got.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq("tx_frame_count", tx_got.size(), n);
    endtask

    task automatic read_data_check(input string tag);
        logic [31:0] d, e;
        e = (rxm.size() != 0) ? {24'h0, rxm.pop_front()} : 32'h0;
        bus_read(4'h0, d);
        check_eq(tag, d, e);
    endtask

    // Decodes every frame on tx by sampling mid-bit at the current divisor.
    initial begin : tx_mon
        logic prev;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !tx) begin
                tx_start.push_back(cyc);
                repeat (cur_div / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (cur_div) @(negedge clk);
                    b[i] = tx;
                end
                repeat (cur_div) @(negedge clk);
                if (!tx) tx_stop_bad++;
                tx_got.push_back(b);
            end
            prev = tx;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        int bad_gaps;

        repeat (3) @(negedge clk);
        check_eq("tx_in_reset", {31'h0, tx}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("irq_reset", {31'h0, irq}, 32'h0);
        bus_read(4'h4, d); check_eq("status_reset", d, 32'h0A);
        bus_read(4'h8, d); check_eq("div_reset", d, 32'd434);
        bus_read(4'hC, d); check_eq("ctrl_reset", d, 32'h3);
        check_eq("tx_idle_reset", {31'h0, tx}, 32'h1);

        // Single TX frame at DIV=4
        bus_write(4'h8, 32'd4);
        cur_div = 4;
        bus_write(4'hC, 32'h7);
        bus_write(4'h0, 32'hFFFF_FF55);
        wait_tx(1, 200);
        if (tx_got.size() >= 1) check_eq("tx_byte_55", {24'h0, tx_got[0]}, 32'h55);
        repeat (10) @(negedge clk);
        bus_read(4'h4, d); check_eq("status_tx_done", d, 32'h0A);

        // Fill TX FIFO with transmitter disabled; 17th push is lost
        tx_got.delete(); tx_start.delete();
        bus_write(4'hC, 32'h6);
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            if (i < 16) txm.push_back(b);
            bus_write(4'h0, {24'h0, b});
        end
        bus_read(4'h4, d); check_eq("status_tx_full", d, 32'h09);
        bus_write(4'hC, 32'h7);
        wait_tx(16, 16 * 40 + 200);
        repeat (100) @(negedge clk);
        check_eq("tx_no_17th", tx_got.size(), 16);
        for (int i = 0; i < 16 && i < tx_got.size(); i++)
            check_eq($sformatf("tx_burst_%0d", i), {24'h0, tx_got[i]}, {24'h0, txm[i]});
        bad_gaps = 0;
        for (int i = 1; i < tx_start.size(); i++)
            if (tx_start[i] - tx_start[i-1] != 10 * cur_div) bad_gaps++;
        check_eq("tx_back_to_back", bad_gaps, 0);

        // Single RX frame with rx irq enabled
        send_rx(8'hA3, 1'b1);
        model_rx(8'hA3);
        check_eq("irq_rx", {31'h0, irq}, 32'h1);
        bus_read(4'h4, d); check_eq("status_rx_avail", d, exp_status());
        read_data_check("rx_a3");
        bus_read(4'h4, d); check_eq("status_rx_drained", d, exp_status());
        repeat (2) @(negedge clk);
        check_eq("irq_clear", {31'h0, irq}, 32'h0);

        // Overrun: 17 frames without reading
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            send_rx(b, 1'b1);
            model_rx(b);
        end
        bus_read(4'h4, d); check_eq("status_overrun", d, exp_status());
        for (int i = 0; i < 16; i++) read_data_check($sformatf("rx_fill_%0d", i));
        read_data_check("rx_empty_read");
        bus_write(4'h4, 32'h10);
        m_ovr = 1'b0;
        bus_read(4'h4, d); check_eq("status_ovr_cleared", d, exp_status());

        // Framing error and glitch rejection
        send_rx(8'($urandom), 1'b0);
        m_ferr = 1'b1;
        bus_read(4'h4, d); check_eq("status_frame_err", d, exp_status());
        bus_write(4'h4, 32'h20);
        m_ferr = 1'b0;
        bus_read(4'h4, d); check_eq("status_ferr_cleared", d, exp_status());
        @(negedge clk); rx = 1'b0;
        @(negedge clk); rx = 1'b1;
        repeat (60) @(negedge clk);
        bus_read(4'h4, d); check_eq("status_glitch", d, exp_status());

        // DIV below minimum behaves as 2
        bus_write(4'h8, 32'd1);
        cur_div = 2;
        tx_got.delete();
        b = 8'($urandom);
        bus_write(4'h0, {24'h0, b});
        wait_tx(1, 100);
        if (tx_got.size() >= 1) check_eq("tx_div_min", {24'h0, tx_got[0]}, {24'h0, b});
        b = 8'($urandom);
        send_rx(b, 1'b1);
        model_rx(b);
        read_data_check("rx_div_min");

        // Random mix of receptions, data reads and status reads at DIV=4
        bus_write(4'h8, 32'd4);
        cur_div = 4;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: begin
                    b = 8'($urandom);
                    send_rx(b, 1'b1);
                    model_rx(b);
                end
                1: read_data_check($sformatf("rand_data_%0d", i));
                default: begin
                    bus_read(4'h4, d);
                    check_eq($sformatf("rand_status_%0d", i), d, exp_status());
                end
            endcase
        end
        check_eq("tx_stop_bits", tx_stop_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_mmio_fifo.md
Name: uart_mmio_fifo

Overview:
Memory-mapped UART peripheral for the single-cycle RISC-V SoC, successor to the fixed-rate, unbuffered UART. It adds parametrised TX/RX FIFOs, a runtime-programmable baud divisor, sticky error flags and an interrupt output. It sits behind the memory controller, selected by its enable line, and drives the read-data mux like the RAM and GPIO slaves.

Parameters:
DATA_WIDTH, 32, bus data width; UART bytes sit in bits [7:0], upper bits read 0
FIFO_DEPTH, 16, entries per TX and RX FIFO; power of two, minimum 2
DIV_WIDTH, 16, width of the baud divisor register
DEFAULT_DIV, 434, reset divisor in clk cycles per bit (50 MHz / 115200)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
en  in  1  slave select from the memory controller
we  in  1  write strobe, valid with en
re  in  1  read strobe, valid with en
addr  in  4  byte offset; addr[3:2] selects the register
wdata  in  DATA_WIDTH  write data
rdata  out  DATA_WIDTH  read data, combinational from addr
irq  out  1  level interrupt
tx  out  1  serial out, idles high
rx  in  1  serial in, asynchronous

Behaviour:
- Register map:
  - 0x0 DATA: write pushes wdata[7:0] to TX FIFO; read returns RX head and pops it on the clock edge.
  - 0x4 STATUS: bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 overrun (sticky), bit5 frame_err (sticky), bit6 tx_busy. Writing 1 to bit4/bit5 clears that bit.
  - 0x8 DIV: read/write, DIV_WIDTH bits.
  - 0xC CTRL: bit0 tx_en, bit1 rx_en, bit2 rx_irq_en, bit3 txe_irq_en.
- Reset values:
  - tx=1, irq=0, rdata follows addr.
  - FIFOs empty. STATUS=0x0A.
  - DIV=DEFAULT_DIV. CTRL=0x3.
  - TX/RX FSMs in IDLE. All counters 0.
- Register access rules:
  - Register write takes effect at the clock edge when en&we.
  - Pop occurs only when en&re&addr[3:2]==0 and RX FIFO is non-empty. A read of an empty RX FIFO returns 0 and has no side effect.
  - Push to a full TX FIFO is dropped silently. Software must poll tx_full.
- Simultaneous push and pop on the same FIFO in one cycle:
  - Both occur and the count is unchanged.
  - Pop of a full RX FIFO while a byte arrives: the byte is stored and no overrun is flagged.
- TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
  - Leaves IDLE when tx_en=1 and the TX FIFO is non-empty; the pop happens on that transition.
  - Each state/bit lasts DIV cycles. tx_busy=1 outside IDLE.
  - Back-to-back bytes: STOP goes directly to START if the FIFO is non-empty.
- RX path:
  - rx passes through a 2-FF synchroniser.
  - FSM: IDLE -> START -> DATA -> STOP.
  - A falling edge in IDLE (with rx_en=1) starts a half-DIV count. If the line is still low at mid-start, go to DATA; otherwise return to IDLE (glitch reject).
  - Data bits are sampled every DIV cycles at mid-bit.
  - At STOP: if the sample is 0, set frame_err and discard the byte. Else push; if the FIFO is full, drop the byte and set overrun.
- DIV: values below 2 are treated as 2. A write to DIV while a frame is in progress takes effect at the next bit boundary.
- irq = (rx_irq_en & ~rx_empty) | (txe_irq_en & tx_empty & ~tx_busy) | overrun | frame_err. Registered: one-cycle latency.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide. Full/empty comes from the MSB compare and pointers wrap naturally.
- Clearing tx_en or rx_en mid-frame finishes the current frame, then holds the FSM in IDLE.
- Reset asserted mid-frame: tx forced to 1 immediately; FIFOs and FSMs cleared asynchronously.

Optional Feature:
UART_PARITY_EN:
- Defined:
  - CTRL bit4 (par_odd) is added; 0 = even parity, 1 = odd parity.
  - TX inserts a PARITY state between DATA and STOP.
  - RX checks parity; on mismatch it sets STATUS bit7 par_err (sticky, write-1-clear, included in irq) and discards the byte.
- Undefined: 8N1 only; CTRL bit4 and STATUS bit7 read 0.

Test Plan:
- Reset release with DIV=434: read 0x4 -> 0x0A, 0x8 -> 434, 0xC -> 0x3, tx=1.
- Set DIV=4, write 0x55 to 0x0 -> tx shows low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles. tx_busy drops afterwards.
- Write 17 bytes with tx_en=0 at FIFO_DEPTH=16 -> tx_full=1 and the 17th byte is lost. Set tx_en=1 -> exactly 16 frames back-to-back, no idle gap.
- Drive rx with 0xA3 at DIV=4 -> rx_empty=0 and irq=1 (rx_irq_en=1). Read 0x0 -> 0x000000A3, then rx_empty=1.
- Send 17 frames without reading -> overrun=1 and the FIFO holds the first 16. Write 0x10 to 0x4 -> overrun=0.
- Frame with stop bit 0 -> frame_err=1 and nothing pushed. A 1-cycle low glitch on rx -> no frame received.
